sub_bytes_engine: RTL and testbench



---
 rtl/sub_bytes_if.sv | 24 ++
 rtl/sub_bytes_engine.sv | 113 +++++++++++
 tb/tb_sub_bytes_engine.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sub_bytes_if.sv
// Block-level handshake bundle for sub_bytes_engine: input state stream, output state stream, status.
// With SUB_BYTES_STATS_EN defined, a delivered-block counter is added.
interface sub_bytes_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;
`ifdef SUB_BYTES_STATS_EN
    logic [15:0]  blk_count;

    modport master (output in_valid, in_state, out_ready,
                    input  in_ready, out_valid, out_state, busy, blk_count);
    modport slave  (input  in_valid, in_state, out_ready,
                    output in_ready, out_valid, out_state, busy, blk_count);
`else
    modport master (output in_valid, in_state, out_ready,
                    input  in_ready, out_valid, out_state, busy);
    modport slave  (input  in_valid, in_state, out_ready,
                    output in_ready, out_valid, out_state, busy);
`endif
endinterface

// File: rtl/sub_bytes_engine.sv
// Sequential AES SubBytes: LANES forward S-box lookups per cycle, 16/LANES beats per block.
// Optional SUB_BYTES_STATS_EN adds a 16-bit wrapping count of delivered blocks.
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic       clk,
    input  logic       rst,
    sub_bytes_if.slave bus
);
    localparam int BEATS = 16 / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // FIPS-197 forward S-box; entry 0 sits in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [127:0]       work_q, result_q, result_d;
    logic               in_ready_q, out_valid_q, busy_q;
    logic [LANES-1:0][7:0] lane_in, lane_out;
    logic               last_beat;

    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        lane_in = '0;
        for (int l = 0; l < LANES; l++)
            lane_in[l] = work_q[8*(int'(cnt_q)*LANES + l) +: 8];
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_out[g] = SBOX[lane_in[g]];
    end

    // Only the current beat's byte positions change; the rest of the result holds.
    always_comb begin
        result_d = result_q;
        for (int l = 0; l < LANES; l++)
            result_d[8*(int'(cnt_q)*LANES + l) +: 8] = lane_out[l];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    work_q     <= bus.in_state;
                    cnt_q      <= '0;
                    state_q    <= BUSY;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
                BUSY: begin
                    result_q <= result_d;
                    if (last_beat) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = result_q;
    assign bus.busy      = busy_q;

`ifdef SUB_BYTES_STATS_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               blk_cnt_q <= '0;
        else if (out_valid_q && bus.out_ready) blk_cnt_q <= blk_cnt_q + 16'd1;
    end

    assign bus.blk_count = blk_cnt_q;
`endif
endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine at LANES = 1, 2, 4, 16; one engine is steered at a time via sel.
module tb_sub_bytes_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int           checks = 0;
    int           passed = 0;
    int           sel    = 4;
    logic         iv     = 1'b0;
    logic         ordy   = 1'b0;
    logic [127:0] ist    = '0;

    sub_bytes_if if1 ();
    sub_bytes_if if2 ();
    sub_bytes_if if4 ();
    sub_bytes_if if16 ();

    assign if1.in_valid   = (sel == 1)  && iv;
    assign if2.in_valid   = (sel == 2)  && iv;
    assign if4.in_valid   = (sel == 4)  && iv;
    assign if16.in_valid  = (sel == 16) && iv;
    assign if1.out_ready  = (sel == 1)  && ordy;
    assign if2.out_ready  = (sel == 2)  && ordy;
    assign if4.out_ready  = (sel == 4)  && ordy;
    assign if16.out_ready = (sel == 16) && ordy;
    assign if1.in_state   = ist;
    assign if2.in_state   = ist;
    assign if4.in_state   = ist;
    assign if16.in_state  = ist;

    sub_bytes_engine #(.LANES(1))  u1  (.clk(clk), .rst(rst), .bus(if1.slave));
    sub_bytes_engine #(.LANES(2))  u2  (.clk(clk), .rst(rst), .bus(if2.slave));
    sub_bytes_engine #(.LANES(4))  u4  (.clk(clk), .rst(rst), .bus(if4.slave));
    sub_bytes_engine #(.LANES(16)) u16 (.clk(clk), .rst(rst), .bus(if16.slave));

    logic         ov, ir, bz;
    logic [127:0] os;
    always_comb begin
        ov = if4.out_valid; ir = if4.in_ready; bz = if4.busy; os = if4.out_state;
        case (sel)
            1:  begin ov = if1.out_valid;  ir = if1.in_ready;  bz = if1.busy;  os = if1.out_state;  end
            2:  begin ov = if2.out_valid;  ir = if2.in_ready;  bz = if2.busy;  os = if2.out_state;  end
            16: begin ov = if16.out_valid; ir = if16.in_ready; bz = if16.busy; os = if16.out_state; end
            default: ;
        endcase
    end

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] ALL63    = {16{8'h63}};

    // Accept one block on engine s; returns cycles from accept edge to out_valid (41 = timed out).
    task automatic run_block(input int s, input logic [127:0] d, output int lat, output logic flags_ok);
        @(negedge clk); sel = s; iv = 1'b1; ist = d;
        @(posedge clk); #1 iv = 1'b0;
        lat = 0; flags_ok = 1'b1;
        while (lat <= 40) begin
            @(negedge clk);
            if (ov === 1'b1) break;
            if (!(bz === 1'b1 && ir === 1'b0)) flags_ok = 1'b0;
            lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clk); ordy = 1'b1;
        @(posedge clk); #1 ordy = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            sel = (k == 3) ? 16 : (1 << k); #1;
            checks++; if (ir !== 1'b1) $display("FAIL reset_in_ready L%0d: got %b want 1", sel, ir); else passed++;
            checks++; if (ov !== 1'b0) $display("FAIL reset_out_valid L%0d: got %b want 0", sel, ov); else passed++;
            checks++; if (bz !== 1'b0) $display("FAIL reset_busy L%0d: got %b want 0", sel, bz); else passed++;
            checks++; if (os !== '0) $display("FAIL reset_out_state L%0d: got %h want 0", sel, os); else passed++;
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic ok;
        run_block(4, '0, lat, ok);
        checks++; if (lat !== 4) $display("FAIL basic_latency: got %0d want 4", lat); else passed++;
        checks++; if (ok !== 1'b1) $display("FAIL basic_busy_ready: got %b want 1", ok); else passed++;
        checks++; if (os !== ALL63) $display("FAIL basic_out_state: got %h want %h", os, ALL63); else passed++;
        checks++; if (ir !== 1'b0) $display("FAIL basic_in_ready_done: got %b want 0", ir); else passed++;
        handshake();
        @(negedge clk);
        checks++; if (ir !== 1'b1 || ov !== 1'b0) $display("FAIL basic_after_hs: got ir=%b ov=%b want 1/0", ir, ov); else passed++;
    endtask

    task automatic test_fips();
        int lat; logic ok;
        run_block(1, FIPS_IN, lat, ok);
        checks++; if (lat !== 16) $display("FAIL fips_l1_latency: got %0d want 16", lat); else passed++;
        checks++; if (os !== FIPS_OUT) $display("FAIL fips_l1_state: got %h want %h", os, FIPS_OUT); else passed++;
        handshake();
        run_block(16, FIPS_IN, lat, ok);
        checks++; if (lat !== 1) $display("FAIL fips_l16_latency: got %0d want 1", lat); else passed++;
        checks++; if (os !== FIPS_OUT) $display("FAIL fips_l16_state: got %h want %h", os, FIPS_OUT); else passed++;
        handshake();
    endtask

    task automatic test_spot_bytes();
        int lat; logic ok;
        run_block(2, 128'hff000000_00530000_00000100_00000000, lat, ok);
        checks++; if (lat !== 8) $display("FAIL spot_latency: got %0d want 8", lat); else passed++;
        checks++; if (os !== 128'h16636363_63ed6363_63637c63_63636363)
            $display("FAIL spot_state: got %h want 16636363_63ed6363_63637c63_63636363", os); else passed++;
        handshake();
    endtask

    task automatic test_backpressure();
        int lat; logic ok, stable;
        logic [127:0] held;
        run_block(4, FIPS_IN, lat, ok);
        held = os; stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin iv = 1'b1; ist = {16{8'hff}}; end
            if (c == 4) iv = 1'b0;
            @(negedge clk);
            if (os !== held || ov !== 1'b1 || ir !== 1'b0) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) $display("FAIL bp_hold: got %b want 1", stable); else passed++;
        checks++; if (held !== FIPS_OUT) $display("FAIL bp_state: got %h want %h", held, FIPS_OUT); else passed++;
        handshake();
        @(negedge clk);
        checks++; if (ir !== 1'b1 || ov !== 1'b0) $display("FAIL bp_idle: got ir=%b ov=%b want 1/0", ir, ov); else passed++;
        iv = 1'b1; ist = {16{8'h53}};
        @(posedge clk); #1 iv = 1'b0;
        @(negedge clk);
        checks++; if (bz !== 1'b1 || ir !== 1'b0) $display("FAIL bp_reaccept: got bz=%b ir=%b want 1/0", bz, ir); else passed++;
        lat = 0;
        while (ov !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        checks++; if (os !== {16{8'hed}}) $display("FAIL bp_second_block: got %h want %h", os, {16{8'hed}}); else passed++;
        handshake();
    endtask

    task automatic test_reset_mid_block();
        int lat; logic ok;
        @(negedge clk); sel = 1; iv = 1'b1; ist = {16{8'h01}};
        @(posedge clk); #1 iv = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (ov !== 1'b0 || ir !== 1'b1 || bz !== 1'b0)
            $display("FAIL midrst_ctrl: got ov=%b ir=%b bz=%b want 0/1/0", ov, ir, bz); else passed++;
        checks++; if (os !== '0) $display("FAIL midrst_state: got %h want 0", os); else passed++;
        @(negedge clk); rst = 1'b0;
        run_block(1, FIPS_IN, lat, ok);
        checks++; if (lat !== 16) $display("FAIL midrst_latency: got %0d want 16", lat); else passed++;
        checks++; if (os !== FIPS_OUT) $display("FAIL midrst_block: got %h want %h", os, FIPS_OUT); else passed++;
        handshake();
    endtask

`ifdef SUB_BYTES_STATS_EN
    task automatic test_stats();
        int lat; logic ok;
        for (int b = 0; b < 3; b++) begin run_block(4, FIPS_IN, lat, ok); handshake(); end
        @(negedge clk);
        checks++; if (if4.blk_count !== 16'd3) $display("FAIL stats_count: got %0d want 3", if4.blk_count); else passed++;
        force u4.blk_cnt_q = 16'hffff;
        @(negedge clk);
        release u4.blk_cnt_q;
        run_block(4, FIPS_IN, lat, ok); handshake();
        @(negedge clk);
        checks++; if (if4.blk_count !== 16'd0) $display("FAIL stats_wrap: got %h want 0000", if4.blk_count); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_fips();
        test_spot_bytes();
        test_backpressure();
        test_reset_mid_block();
`ifdef SUB_BYTES_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
